// File: rtl/matmul_stream_if.sv
// Byte-stream front end for the 2x2 uint8 matrix multiplier: packs eight operand
// bytes, waits out the multiplier latency, then streams four 16-bit results.

module mm_byte_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (clear) q <= '0;
    else if (we)    q <= d;
  end
endmodule

module matmul_stream_if #(
  parameter int ResultLatency = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [15:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_last_o,
  output logic [31:0] operand_a_o,
  output logic [31:0] operand_b_o,
  input  logic [63:0] result_i,
  output logic        busy_o
);
  localparam int         NUM_SLOTS = 8;
  localparam logic [1:0] LAT       = 2'(ResultLatency);

  typedef enum logic [1:0] {LOAD, WAIT, SEND} state_t;

  state_t      state_q, state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic [1:0]  word_cnt_q, word_cnt_d;
  logic        cap;
  logic [63:0] result_q;
  logic        in_hs, out_hs;

  logic [NUM_SLOTS-1:0][7:0] slot;
  logic [3:0][15:0]          elem;

  // Handshake terms include clear_i through the ready/valid decode.
  assign in_ready_o  = (state_q == LOAD) & ~clear_i;
  assign out_valid_o = (state_q == SEND) & ~clear_i;
  assign in_hs       = in_valid_i & in_ready_o;
  assign out_hs      = out_valid_o & out_ready_i;
  assign busy_o      = (state_q != LOAD);

  // Slot g holds byte g of the stream: 0..3 -> a00..a11, 4..7 -> b00..b11.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    mm_byte_slot u_slot (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .clear (clear_i),
      .we    (in_hs && (byte_cnt_q == 3'(g))),
      .d     (in_data_i),
      .q     (slot[g])
    );
  end

  assign operand_a_o = {slot[0], slot[1], slot[2], slot[3]};
  assign operand_b_o = {slot[4], slot[5], slot[6], slot[7]};

  // elem[3] is c00 (top of the packed result), so word w maps to elem[3-w].
  assign elem       = result_q;
  assign out_data_o = (state_q == SEND) ? elem[2'd3 - word_cnt_q] : '0;
  assign out_last_o = (state_q == SEND) && (word_cnt_q == 2'd3);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    word_cnt_d = word_cnt_q;
    cap        = 1'b0;
    unique case (state_q)
      LOAD: if (in_hs) begin
        byte_cnt_d = byte_cnt_q + 3'd1;
        if (byte_cnt_q == 3'd7) state_d = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == LAT) begin
          cap       = 1'b1;
          lat_cnt_d = '0;
          state_d   = SEND;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      SEND: if (out_hs) begin
        word_cnt_d = word_cnt_q + 2'd1;
        if (word_cnt_q == 2'd3) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    if (clear_i) begin
      state_d    = LOAD;
      byte_cnt_d = '0;
      lat_cnt_d  = '0;
      word_cnt_d = '0;
      cap        = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LOAD;
      byte_cnt_q <= '0;
      lat_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      result_q <= '0;
    else if (clear_i) result_q <= '0;
    else if (cap)     result_q <= result_i;
  end
endmodule

// File: tb/tb_matmul_stream_if.sv
// Directed bench: a combinational-multiplier instance (latency 0) and a
// registered-multiplier instance (latency 1) share one input/output stream.

module tb_matmul_stream_if;
  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic        out_last0, out_last1, busy0, busy1;
  logic [15:0] out_data0, out_data1;
  logic [31:0] opa0, opa1, opb0, opb1;
  logic [63:0] res0, res1;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mm(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] c00, c01, c10, c11;
    c00 = a[31:24] * b[31:24] + a[23:16] * b[15:8];
    c01 = a[31:24] * b[23:16] + a[23:16] * b[7:0];
    c10 = a[15:8]  * b[31:24] + a[7:0]   * b[15:8];
    c11 = a[15:8]  * b[23:16] + a[7:0]   * b[7:0];
    return {c00, c01, c10, c11};
  endfunction

  assign res0 = mm(opa0, opb0);
  always @(posedge clk) res1 <= mm(opa1, opb1);

  matmul_stream_if #(.ResultLatency(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .out_data_o(out_data0), .out_valid_o(out_valid0), .out_ready_i(out_ready),
    .out_last_o(out_last0), .operand_a_o(opa0), .operand_b_o(opb0),
    .result_i(res0), .busy_o(busy0)
  );

  matmul_stream_if #(.ResultLatency(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .out_data_o(out_data1), .out_valid_o(out_valid1), .out_ready_i(out_ready),
    .out_last_o(out_last1), .operand_a_o(opa1), .operand_b_o(opb1),
    .result_i(res1), .busy_o(busy1)
  );

  // Drives cnt bytes; hs_edge is the posedge number of the last accepted byte.
  task automatic send_bytes(input logic [7:0] b[8], input int cnt, input bit rnd,
                            output int hs_edge);
    int i, guard;
    i = 0; guard = 0; hs_edge = -1;
    while (i < cnt && guard < 300) begin
      in_data  = b[i];
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready0) begin i++; hs_edge = cyc + 1; end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (i != cnt) begin
      n_err++;
      $display("FAIL send_timeout: accepted %0d bytes, required %0d", i, cnt);
    end
  endtask

  task automatic collect(input int which, input int stall_word, input int stall_n,
                         input logic [15:0] hold_exp,
                         output logic [15:0] d[4], output logic l[4], output int first_v,
                         output int last_edge, output int rdy_viol, output int hold_n,
                         output int hold_viol);
    int n, guard, stalled;
    logic ov, ol, rdy;
    logic [15:0] od;
    n = 0; guard = 0; stalled = 0; first_v = -1; last_edge = -1;
    rdy_viol = 0; hold_n = 0; hold_viol = 0;
    for (int k = 0; k < 4; k++) begin d[k] = '0; l[k] = 1'b0; end
    while (n < 4 && guard < 60) begin
      ov = which ? out_valid1 : out_valid0;
      if (ov && n == stall_word && stalled < stall_n) begin
        out_ready = 1'b0; stalled++;
      end else out_ready = 1'b1;
      @(negedge clk);
      ov  = which ? out_valid1 : out_valid0;
      od  = which ? out_data1 : out_data0;
      ol  = which ? out_last1 : out_last0;
      rdy = which ? in_ready1 : in_ready0;
      if (rdy) rdy_viol++;
      if (ov && first_v < 0) first_v = cyc;
      if (ov && !out_ready) begin
        hold_n++;
        if (od !== hold_exp) hold_viol++;
      end
      if (ov && out_ready) begin
        d[n] = od; l[n] = ol; n++;
        if (n == 4) last_edge = cyc + 1;
      end
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b1;
    n_cmp++;
    if (n != 4) begin
      n_err++;
      $display("FAIL collect_timeout: got %0d elements, required 4", n);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    out_ready = 1'b1;
    while ((busy0 || busy1) && g < 50) begin @(posedge clk); #1; g++; end
    n_cmp++;
    if (busy0 || busy1) begin
      n_err++;
      $display("FAIL drain_timeout: busy0=%0b busy1=%0b, required 0", busy0, busy1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: %0b want 1", in_ready0); end
    n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: %0b want 0", out_valid0); end
    n_cmp++; if (out_last0 !== 1'b0) begin n_err++; $display("FAIL rst_out_last: %0b want 0", out_last0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL rst_busy: %0b want 0", busy0); end
    n_cmp++; if (out_data0 !== 16'h0) begin n_err++; $display("FAIL rst_out_data: %h want 0", out_data0); end
    n_cmp++; if (opa0 !== 32'h0 || opb0 !== 32'h0) begin n_err++; $display("FAIL rst_operands: %h %h want 0 0", opa0, opb0); end
    n_cmp++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin n_err++; $display("FAIL rst_dut1: rdy=%0b vld=%0b want 1 0", in_ready1, out_valid1); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_std(input string tag, input logic [15:0] d[4], input logic l[4],
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] e[4];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (d[k] !== e[k]) begin n_err++; $display("FAIL %s_data%0d: %0d want %0d", tag, k, d[k], e[k]); end
      n_cmp++;
      if (l[k] !== (k == 3)) begin n_err++; $display("FAIL %s_last%0d: %0b want %0b", tag, k, l[k], (k == 3)); end
    end
  endtask

  task automatic test_basic();
    logic [7:0] b[8]; logic [15:0] d[4]; logic l[4];
    int hs, fv, le, rv, hn, hv;
    b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_bytes(b, 8, 1'b0, hs);
    collect(0, -1, 0, 16'd0, d, l, fv, le, rv, hn, hv);
    check_std("basic", d, l, 16'd19, 16'd22, 16'd43, 16'd50);
    n_cmp++; if (fv - hs != 1) begin n_err++; $display("FAIL basic_latency: %0d want 1", fv - hs); end
    n_cmp++; if (rv != 0) begin n_err++; $display("FAIL basic_in_ready_busy: %0d cycles want 0", rv); end
    @(negedge clk);
    n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL basic_ready_return: %0b want 1", in_ready0); end
    drain();
  endtask

  task automatic test_overflow();
    logic [7:0] b[8]; logic [15:0] d[4]; logic l[4];
    int hs, fv, le, rv, hn, hv;
    for (int k = 0; k < 8; k++) b[k] = 8'hFF;
    send_bytes(b, 8, 1'b0, hs);
    collect(0, -1, 0, 16'd0, d, l, fv, le, rv, hn, hv);
    check_std("ovf", d, l, 16'hFC02, 16'hFC02, 16'hFC02, 16'hFC02);
    drain();
  endtask

  task automatic test_latency();
    logic [7:0] b[8]; logic [15:0] d[4]; logic l[4];
    int hs, fv, le, rv, hn, hv;
    b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_bytes(b, 8, 1'b0, hs);
    n_cmp++; if (opa1 !== 32'h01020304) begin n_err++; $display("FAIL lat_operand_a: %h want 01020304", opa1); end
    n_cmp++; if (opb1 !== 32'h05060708) begin n_err++; $display("FAIL lat_operand_b: %h want 05060708", opb1); end
    collect(1, -1, 0, 16'd0, d, l, fv, le, rv, hn, hv);
    check_std("lat", d, l, 16'd19, 16'd22, 16'd43, 16'd50);
    n_cmp++; if (fv - hs != 2) begin n_err++; $display("FAIL lat_latency: %0d want 2", fv - hs); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] b[8]; logic [15:0] d[4]; logic l[4];
    int hs, fv, le, rv, hn, hv;
    b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_bytes(b, 8, 1'b1, hs);
    collect(0, 1, 3, 16'd22, d, l, fv, le, rv, hn, hv);
    check_std("bp", d, l, 16'd19, 16'd22, 16'd43, 16'd50);
    n_cmp++; if (hn != 3) begin n_err++; $display("FAIL bp_stall_cycles: %0d want 3", hn); end
    n_cmp++; if (hv != 0) begin n_err++; $display("FAIL bp_hold: %0d unstable cycles want 0", hv); end
    n_cmp++; if (rv != 0) begin n_err++; $display("FAIL bp_in_ready: %0d cycles high want 0", rv); end
    drain();
  endtask

  task automatic test_clear();
    logic [7:0] b[8]; logic [15:0] d[4]; logic l[4];
    int hs, fv, le, rv, hn, hv;
    b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_bytes(b, 5, 1'b0, hs);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk);
    n_cmp++; if (in_ready0 !== 1'b0) begin n_err++; $display("FAIL clr_in_ready: %0b want 0", in_ready0); end
    n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL clr_out_valid: %0b want 0", out_valid0); end
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    n_cmp++; if (opa0 !== 32'h0) begin n_err++; $display("FAIL clr_operand_a: %h want 0", opa0); end
    n_cmp++; if (opb0 !== 32'h0) begin n_err++; $display("FAIL clr_operand_b: %h want 0", opb0); end
    send_bytes(b, 8, 1'b0, hs);
    collect(0, -1, 0, 16'd0, d, l, fv, le, rv, hn, hv);
    check_std("clr", d, l, 16'd19, 16'd22, 16'd43, 16'd50);
    drain();
  endtask

  task automatic test_reset_mid_send();
    logic [7:0] b[8]; logic [15:0] d[4]; logic l[4];
    int hs, fv, le, rv, hn, hv, g;
    b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_bytes(b, 8, 1'b0, hs);
    out_ready = 1'b1; g = 0;
    @(negedge clk);
    while (!out_valid0 && g < 20) begin @(negedge clk); g++; end
    @(posedge clk); #2;
    n_cmp++; if (out_valid0 !== 1'b1 || out_data0 !== 16'd22) begin n_err++; $display("FAIL rms_pre: vld=%0b data=%0d want 1 22", out_valid0, out_data0); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL rms_out_valid: %0b want 0", out_valid0); end
    n_cmp++; if (out_data0 !== 16'h0 || out_last0 !== 1'b0) begin n_err++; $display("FAIL rms_out: data=%h last=%0b want 0 0", out_data0, out_last0); end
    n_cmp++; if (busy0 !== 1'b0 || in_ready0 !== 1'b1) begin n_err++; $display("FAIL rms_state: busy=%0b rdy=%0b want 0 1", busy0, in_ready0); end
    n_cmp++; if (opa0 !== 32'h0 || opb0 !== 32'h0) begin n_err++; $display("FAIL rms_operands: %h %h want 0 0", opa0, opb0); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    b = '{8'd2, 8'd0, 8'd0, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4};
    send_bytes(b, 8, 1'b0, hs);
    collect(0, -1, 0, 16'd0, d, l, fv, le, rv, hn, hv);
    check_std("rms", d, l, 16'd2, 16'd4, 16'd9, 16'd12);
    drain();
  endtask

  initial begin
    rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_overflow();
    test_latency();
    test_backpressure();
    test_clear();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/matmul_stream_if.md
# matmul_stream_if

Stream-side front end for the fixed-size uint8 2x2 matrix multiplier. It accepts a byte stream of eight operand bytes (matrix A, then matrix B, row-major) on a valid/ready input, and drives the packed 32-bit operands to the multiplier. It captures the multiplier's 64-bit packed result after a configurable latency. It returns the four 16-bit result elements on a valid/ready output stream, c00 first, with a last flag on c11.

## Interface
- ResultLatency, default 0: cycles between stable operands and a valid `result_i`. Legal range is 0..3; use 0 for a combinational multiplier and 1 for a registered one.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- clear_i  in  1  synchronous abort. Returns the block to LOAD.
- in_data_i  in  8  operand byte.
- in_valid_i  in  1  operand byte valid.
- in_ready_o  out  1  block accepts a byte.
- out_data_o  out  16  result element.
- out_valid_o  out  1  result element valid.
- out_ready_i  in  1  sink accepts the element.
- out_last_o  out  1  marks the 4th element (c11).
- operand_a_o  out  32  to multiplier: {a00,a01,a10,a11}, with a00 in [31:24].
- operand_b_o  out  32  to multiplier: {b00,b01,b10,b11}, with b00 in [31:24].
- result_i  in  64  from multiplier: {c00,c01,c10,c11}, with c00 in [63:48].
- busy_o  out  1  high in any state other than LOAD.

## Operation
- States are LOAD, WAIT and SEND, with a 3-bit byte counter, a 2-bit latency counter and a 2-bit word counter.
- **Reset:**
  - State is LOAD and all counters are 0.
  - operand_a_o and operand_b_o are 0, and the result register is 0.
  - out_valid_o, out_last_o and busy_o are 0.
  - out_data_o is 0.
  - in_ready_o = 1, because it is decoded from state.
- **LOAD:**
  - in_ready_o = 1 (subject to clear_i).
  - Each handshake (in_valid_i & in_ready_o) writes the byte and increments the byte counter.
  - Bytes 0..3 go to A slots a00, a01, a10, a11. Bytes 4..7 go to B slots b00..b11.
  - Each byte lands in its slot register immediately, so the operand outputs change progressively.
  - On the handshake of byte 7, the byte counter wraps to 0 and the state moves to WAIT.
- **WAIT:**
  - in_ready_o = 0 and the operand outputs are frozen.
  - The latency counter counts from 0.
  - In the cycle where the counter equals ResultLatency, result_i is captured into the result register and the state moves to SEND.
- **SEND:**
  - out_valid_o = 1 and out_data_o = the element selected by the word counter (0→c00, 1→c01, 2→c10, 3→c11).
  - out_last_o = 1 when the word counter is 3.
  - On each handshake the word counter increments.
  - On the handshake with out_last_o = 1, the word counter wraps to 0 and the state moves to LOAD.
  - out_data_o and out_last_o stay stable while out_valid_o is high and out_ready_i is low.
- **Width rule:** the block does no arithmetic. Elements are passed through exactly as the multiplier produces them, i.e. sums modulo 2^16.
- **clear_i:**
  - While clear_i is high, in_ready_o and out_valid_o are forced to 0, so no handshake can complete in that cycle.
  - At the clock edge, the state goes to LOAD, all counters to 0, and the operand and result registers to 0.
  - clear_i has priority over every other transition.
- Asserting rst_ni low mid-operation immediately forces the reset values listed above.
- Input and output phases never overlap. The block holds a single transaction at a time.

## Timing
- The final input byte is accepted at edge k.
- WAIT occupies cycles k..k+ResultLatency. result_i is sampled at edge k+1+ResultLatency.
- out_valid_o is high from edge k+1+ResultLatency. The output phase therefore starts 1+ResultLatency cycles after the last input handshake.
- The output phase takes 4 cycles minimum, plus one cycle per cycle of out_ready_i low.
- in_ready_o rises in the cycle after the c11 handshake edge.
- Minimum period per transaction, with no stalls: 8 + 1 + ResultLatency + 4 = 13 + ResultLatency cycles.
- in_ready_o, out_valid_o, out_data_o, out_last_o and busy_o are decoded from registers only; they have no combinational path from the *_valid_i or *_ready_i inputs.

## Test plan
- **Basic transaction:** ResultLatency=0, with the bench's multiplier attached. Send bytes 1,2,3,4,5,6,7,8 back-to-back with out_ready_i=1.
  - Required: outputs 19, 22, 43, 50; last flag on 50 only; first out_valid_o exactly 1 cycle after the 8th input handshake; in_ready_o high again 1 cycle after 50.
- **Overflow:** send all bytes 0xFF.
  - Required: four elements of 0xFC02 (130050 mod 2^16).
- **Latency and packing:** ResultLatency=1 with a registered multiplier model.
  - Required: first out_valid_o 2 cycles after the last input handshake, and values identical to test 1.
  - Also check operand_a_o=0x01020304 and operand_b_o=0x05060708.
- **Backpressure:** hold out_ready_i low for 3 cycles on c01, and toggle in_valid_i randomly during LOAD.
  - Required: out_data_o holds 22 steadily while stalled, no element is lost or duplicated, and in_ready_o stays 0 throughout WAIT and SEND.
- **Clear mid-load:** assert clear_i after 5 bytes, then send a fresh set 1..8.
  - Required: no handshake in the clear cycle, operand_a_o=0 after clear, and outputs 19, 22, 43, 50.
- **Reset mid-send:** pull rst_ni low after c00 is accepted.
  - Required: out_valid_o drops to 0 asynchronously and all outputs take their reset values. A following clean transaction yields the correct results.
